// File: rtl/err_count_serializer_if.sv
// Counter-snapshot request bus and serial framing outputs of err_count_serializer.
// The master side requests snapshots and reads the serial stream; the serializer is the slave.
interface err_count_serializer_if #(
    parameter int NUM_CHAINS = 20,
    parameter int CNT_W      = 12
);
    logic                          save_data;
    logic [NUM_CHAINS*CNT_W-1:0]   err_counts;
    logic                          DATA_OUT;
    logic                          data_valid;
    logic                          frame_start;
    logic                          frame_done;
    logic                          busy;
    logic                          snap_overrun;

    modport master (
        output save_data, err_counts,
        input  DATA_OUT, data_valid, frame_start, frame_done, busy, snap_overrun
    );

    modport slave (
        input  save_data, err_counts,
        output DATA_OUT, data_valid, frame_start, frame_done, busy, snap_overrun
    );
endinterface

// File: rtl/err_count_serializer.sv
// Snapshots NUM_CHAINS error counters and shifts them out as a framed serial packet.
// Define FRAME_CRC_EN to append a CRC-8 (x^8+x^2+x+1) over the payload.
module err_count_serializer #(
    parameter int          NUM_CHAINS = 20,
    parameter int          CNT_W      = 12,
    parameter logic [7:0]  SYNC_WORD  = 8'hA5
) (
    input  logic                    data_clk,
    input  logic                    reset_n,
    err_count_serializer_if.slave   bus
);
    localparam int PW = NUM_CHAINS * CNT_W;
    localparam int BW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam int CW = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
    localparam logic [BW-1:0] BIT_LAST   = BW'(CNT_W - 1);
    localparam logic [CW-1:0] CHAIN_LAST = CW'(NUM_CHAINS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
`ifdef FRAME_CRC_EN
    localparam logic [1:0] ST_CRC     = 2'd3;
`endif

    logic [1:0]    state_q, state_d;
    logic          save_q, save_d;
    logic          req_q, req_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic [PW-1:0] snap_q, snap_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] chain_cnt_q, chain_cnt_d;
    logic [2:0]    hdr_cnt_q, hdr_cnt_d;
    logic          data_out_q, data_out_d;
    logic          valid_q, valid_d;
    logic          start_q, start_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
`ifdef FRAME_CRC_EN
    logic [7:0]    crc_q, crc_d;
    logic          crc_fb;
`endif

    logic          frame_end;
    logic          launch;
    logic          cur_bit;
    logic [CNT_W-1:0] words [NUM_CHAINS];

    for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_word
        assign words[gi] = snap_q[gi*CNT_W +: CNT_W];
    end

    assign cur_bit = words[chain_cnt_q][bit_cnt_q];

    always_comb begin
        state_d     = state_q;
        save_d      = bus.save_data;
        req_d       = bus.save_data & ~save_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        snap_d      = snap_q;
        bit_cnt_d   = bit_cnt_q;
        chain_cnt_d = chain_cnt_q;
        hdr_cnt_d   = hdr_cnt_q;
        data_out_d  = 1'b0;
        valid_d     = 1'b0;
        start_d     = 1'b0;
        done_d      = 1'b0;
        frame_end   = 1'b0;
        launch      = 1'b0;
`ifdef FRAME_CRC_EN
        crc_d       = crc_q;
        crc_fb      = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_q) launch = 1'b1;
            end
            ST_HEADER: begin
                valid_d    = 1'b1;
                data_out_d = SYNC_WORD[~hdr_cnt_q];
                start_d    = (hdr_cnt_q == 3'd0);
                hdr_cnt_d  = hdr_cnt_q + 3'd1;
                if (hdr_cnt_q == 3'd7) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                valid_d    = 1'b1;
                data_out_d = cur_bit;
`ifdef FRAME_CRC_EN
                crc_fb     = crc_q[7] ^ cur_bit;
                crc_d      = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
`endif
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d   = '0;
                    chain_cnt_d = chain_cnt_q + CW'(1);
                    if (chain_cnt_q == CHAIN_LAST) begin
`ifdef FRAME_CRC_EN
                        state_d = ST_CRC;
`else
                        frame_end = 1'b1;
`endif
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
`ifdef FRAME_CRC_EN
            ST_CRC: begin
                valid_d    = 1'b1;
                data_out_d = crc_q[~hdr_cnt_q];
                hdr_cnt_d  = hdr_cnt_q + 3'd1;
                if (hdr_cnt_q == 3'd7) frame_end = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A request landing on the frame-end edge chains the next frame like a pending one.
        if (frame_end) begin
            done_d    = 1'b1;
            pending_d = 1'b0;
            if (pending_q | req_q) launch = 1'b1;
            else                   state_d = ST_IDLE;
            if (pending_q & req_q) overrun_d = 1'b1;
        end else if ((state_q != ST_IDLE) && req_q) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        if (launch) begin
            snap_d      = bus.err_counts;
            state_d     = ST_HEADER;
            bit_cnt_d   = '0;
            chain_cnt_d = '0;
            hdr_cnt_d   = '0;
`ifdef FRAME_CRC_EN
            crc_d       = 8'h00;
`endif
        end

        busy_d = valid_d;
    end

    always_ff @(posedge data_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            save_q      <= 1'b0;
            req_q       <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            snap_q      <= '0;
            bit_cnt_q   <= '0;
            chain_cnt_q <= '0;
            hdr_cnt_q   <= '0;
            data_out_q  <= 1'b0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FRAME_CRC_EN
            crc_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            save_q      <= save_d;
            req_q       <= req_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            snap_q      <= snap_d;
            bit_cnt_q   <= bit_cnt_d;
            chain_cnt_q <= chain_cnt_d;
            hdr_cnt_q   <= hdr_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            start_q     <= start_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef FRAME_CRC_EN
            crc_q       <= crc_d;
`endif
        end
    end

    assign bus.DATA_OUT     = data_out_q;
    assign bus.data_valid   = valid_q;
    assign bus.frame_start  = start_q;
    assign bus.frame_done   = done_q;
    assign bus.busy         = busy_q;
    assign bus.snap_overrun = overrun_q;
endmodule

// File: tb/tb_err_count_serializer.sv
// Directed bench for err_count_serializer: default 20x12 instance plus a 3x5 instance.
module tb_err_count_serializer;
    logic data_clk = 1'b0;
    logic reset_n  = 1'b0;
    logic sel      = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 data_clk = ~data_clk;

    err_count_serializer_if #(.NUM_CHAINS(20), .CNT_W(12)) bus_a ();
    err_count_serializer_if #(.NUM_CHAINS(3),  .CNT_W(5))  bus_b ();

    err_count_serializer #(.NUM_CHAINS(20), .CNT_W(12), .SYNC_WORD(8'hA5)) dut_a (
        .data_clk (data_clk),
        .reset_n  (reset_n),
        .bus      (bus_a.slave)
    );

    err_count_serializer #(.NUM_CHAINS(3), .CNT_W(5), .SYNC_WORD(8'hA5)) dut_b (
        .data_clk (data_clk),
        .reset_n  (reset_n),
        .bus      (bus_b.slave)
    );

    logic mon_data, mon_valid, mon_start, mon_done, mon_busy;
    assign mon_data  = sel ? bus_b.DATA_OUT    : bus_a.DATA_OUT;
    assign mon_valid = sel ? bus_b.data_valid  : bus_a.data_valid;
    assign mon_start = sel ? bus_b.frame_start : bus_a.frame_start;
    assign mon_done  = sel ? bus_b.frame_done  : bus_a.frame_done;
    assign mon_busy  = sel ? bus_b.busy        : bus_a.busy;

    logic [511:0] exp_v, cap_v;
    int           exp_len;
    logic [7:0]   exp_crc, cap_crc;
    logic         start_ok, done_ok, valid_ok;

    task automatic tick;
        @(posedge data_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame: header MSB first, chains 0.. LSB first, optional CRC MSB first.
    task automatic build_exp(input int nc, input int cw, input logic [239:0] flat);
        logic [7:0] s;
        logic [7:0] c;
        logic       bt, fb;
        int         idx;
        s = 8'hA5;
        c = 8'h00;
        idx = 0;
        exp_v = '0;
        for (int i = 0; i < 8; i++) begin
            exp_v[idx] = s[7-i];
            idx++;
        end
        for (int k = 0; k < nc; k++) begin
            for (int b = 0; b < cw; b++) begin
                bt = flat[k*cw+b];
                exp_v[idx] = bt;
                idx++;
                fb = c[7] ^ bt;
                c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
`ifdef FRAME_CRC_EN
        for (int i = 0; i < 8; i++) begin
            exp_v[idx] = c[7-i];
            idx++;
        end
`endif
        exp_len = idx;
        exp_crc = c;
    endtask

    task automatic pulse;
        if (sel) bus_b.save_data = 1'b1; else bus_a.save_data = 1'b1;
        tick;
        bus_a.save_data = 1'b0;
        bus_b.save_data = 1'b0;
    endtask

    // Captures one frame; optionally raises requests / changes A's counters at given bit indices.
    task automatic capture(input int req1, input int req2, input int chg_at,
                           input logic [239:0] chg_val, input int abort_at, output int wait_cyc);
        cap_v    = '0;
        start_ok = 1'b1;
        done_ok  = 1'b1;
        valid_ok = 1'b1;
        wait_cyc = 0;
        while (!mon_valid && wait_cyc < 20) begin
            tick;
            wait_cyc++;
        end
        if (!mon_valid) begin
            chk("frame_timeout", mon_valid, 1'b1);
            return;
        end
        for (int i = 0; i < exp_len; i++) begin
            if (i == abort_at) return;
            cap_v[i] = mon_data;
            if (mon_start !== (i == 0))           start_ok = 1'b0;
            if (mon_done  !== (i == exp_len - 1)) done_ok  = 1'b0;
            if (mon_valid !== 1'b1 || mon_busy !== 1'b1) valid_ok = 1'b0;
            if (i == req1 || i == req2) begin
                if (sel) bus_b.save_data = 1'b1; else bus_a.save_data = 1'b1;
            end
            if (i == req1 + 1 || i == req2 + 1) begin
                bus_a.save_data = 1'b0;
                bus_b.save_data = 1'b0;
            end
            if (i == chg_at) bus_a.err_counts = chg_val;
            tick;
        end
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_bits"},  cap_v, exp_v);
        chk({tag, "_start"}, start_ok, 1'b1);
        chk({tag, "_done"},  done_ok, 1'b1);
        chk({tag, "_valid"}, valid_ok, 1'b1);
    endtask

    logic [239:0] flat_k, flat_ff, flat_p3;
    logic [239:0] flat_b;
    int           w;
    logic         seen;

    initial begin
        bus_a.save_data  = 1'b0;
        bus_a.err_counts = '0;
        bus_b.save_data  = 1'b0;
        bus_b.err_counts = '0;
        for (int k = 0; k < 20; k++) begin
            flat_k[k*12 +: 12]  = 12'(k + 1);
            flat_p3[k*12 +: 12] = 12'(k * 37 + 3);
        end
        flat_ff = '1;

        repeat (3) tick;
        chk("rst_data_out",   bus_a.DATA_OUT,     1'b0);
        chk("rst_valid",      bus_a.data_valid,   1'b0);
        chk("rst_start",      bus_a.frame_start,  1'b0);
        chk("rst_done",       bus_a.frame_done,   1'b0);
        chk("rst_busy",       bus_a.busy,         1'b0);
        chk("rst_overrun",    bus_a.snap_overrun, 1'b0);
        reset_n = 1'b1;
        repeat (2) tick;

        // Basic frame; counters change right after the snapshot edge.
        bus_a.err_counts = flat_k;
        build_exp(20, 12, flat_k);
        pulse;
        tick;
        bus_a.err_counts = flat_ff;
        capture(-1, -1, -1, '0, -1, w);
        chk("t1_latency", w, 1);
        check_frame("t1");
        chk("t1_busy_after",  bus_a.busy, 1'b0);
        chk("t1_valid_after", bus_a.data_valid, 1'b0);

        // Pending plus overrun: second frame back-to-back with counters captured at frame end.
        build_exp(20, 12, flat_ff);
        pulse;
        capture(40, 60, 80, flat_p3, -1, w);
        chk("t2_latency", w, 2);
        check_frame("t2a");
        chk("t2_overrun_set", bus_a.snap_overrun, 1'b1);
        build_exp(20, 12, flat_p3);
        capture(-1, -1, -1, '0, -1, w);
        chk("t2_b2b_gap", w, 0);
        check_frame("t2b");
        chk("t2_busy_after", bus_a.busy, 1'b0);
        repeat (5) tick;
        chk("t2_overrun_sticky", bus_a.snap_overrun, 1'b1);

        // Mid-frame reset at payload bit 100, with a pending request that must be discarded.
        build_exp(20, 12, flat_p3);
        pulse;
        capture(50, -1, -1, '0, 108, w);
        chk("t3_partial_bits", cap_v[107:0], exp_v[107:0]);
        chk("t3_valid_pre", bus_a.data_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t3_rst_data",    bus_a.DATA_OUT,     1'b0);
        chk("t3_rst_valid",   bus_a.data_valid,   1'b0);
        chk("t3_rst_busy",    bus_a.busy,         1'b0);
        chk("t3_rst_overrun", bus_a.snap_overrun, 1'b0);
        repeat (2) tick;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (bus_a.data_valid || bus_a.frame_done) seen = 1'b1;
        end
        chk("t3_no_frame_after_rst", seen, 1'b0);

        // Small instance: 3 chains of 5 bits.
        sel = 1'b1;
        flat_b = '0;
        flat_b[14:0] = {5'h1F, 5'h0A, 5'h15};
        bus_b.err_counts = flat_b[14:0];
        build_exp(3, 5, flat_b);
        pulse;
        capture(-1, -1, -1, '0, -1, w);
        chk("t4_latency", w, 2);
        check_frame("t4");
        chk("t4_hand_bits", cap_v[22:0], 23'h7D55A5);
        chk("t4_busy_after", bus_b.busy, 1'b0);

        // All-zero payload, then a single 1 as the last payload bit.
        flat_b = '0;
        bus_b.err_counts = flat_b[14:0];
        build_exp(3, 5, flat_b);
        pulse;
        capture(-1, -1, -1, '0, -1, w);
        check_frame("t5");
        flat_b[14:0] = {5'h10, 5'h00, 5'h00};
        bus_b.err_counts = flat_b[14:0];
        build_exp(3, 5, flat_b);
        pulse;
        capture(-1, -1, -1, '0, -1, w);
        check_frame("t6");
`ifdef FRAME_CRC_EN
        for (int i = 0; i < 8; i++) cap_crc[7-i] = cap_v[23+i];
        chk("t6_crc_byte", cap_crc, 8'h07);
`endif
        chk("t6_busy_after", bus_b.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
